// File: rtl/gps_feed_arbiter.sv
// gps_feed_arbiter: shares one GPS receiver between two NMEA byte feeds.
// A feed owns the receiver from its sentence start until resolve or abort.
module gps_feed_arbiter #(
  parameter int             B         = 8,
  parameter int             Timeout   = 100000,
  parameter logic [B-1:0]   Start     = "$",
  parameter logic [B-1:0]   EndOfLine = 8'h0A
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         a_valid,
  input  logic [B-1:0] a_data,
  input  logic         b_valid,
  input  logic [B-1:0] b_data,
  output logic         rx_load,
  output logic [B-1:0] rx_data,
  output logic         rx_restart,
  input  logic         rx_resolve,
  input  logic         rx_error,
  output logic [1:0]   grant,
  output logic         sentence_ok,
  output logic         sentence_bad,
  output logic [15:0]  ok_count,
  output logic [15:0]  bad_count
);

  localparam int TW = $clog2(Timeout + 1);

  typedef enum logic [1:0] {
    S_Idle,
    S_Lock,
    S_Flush
  } state_t;

  state_t         state, state_d;
  logic [TW-1:0]  timer, timer_d;
  logic           prefer_b, prefer_b_d;
  logic [1:0]     grant_d;
  logic           load_d;
  logic [B-1:0]   data_d;
  logic           ok_d, bad_d;
  logic [15:0]    ok_q, bad_q;

  logic           a_start, b_start, take_b;
  logic           own_v, own_term, timed_out;
  logic [B-1:0]   own_d;

  assign a_start   = a_valid && (a_data == Start);
  assign b_start   = b_valid && (b_data == Start);
  assign take_b    = b_start && (!a_start || prefer_b);
  assign own_v     = grant[1] ? b_valid : a_valid;
  assign own_d     = grant[1] ? b_data : a_data;
  assign own_term  = own_v && (own_d == EndOfLine || own_d == Start);
  assign timed_out = (timer == TW'(Timeout));

  always_comb begin
    state_d    = state;
    timer_d    = timer;
    prefer_b_d = prefer_b;
    grant_d    = grant;
    load_d     = 1'b0;
    data_d     = rx_data;
    ok_d       = 1'b0;
    bad_d      = 1'b0;
    unique case (state)
      S_Idle: begin
        if (a_start || b_start) begin
          grant_d    = take_b ? 2'b10 : 2'b01;
          prefer_b_d = !take_b;
          load_d     = 1'b1;
          data_d     = Start;
          timer_d    = '0;
          state_d    = S_Lock;
        end
      end
      S_Lock: begin
        // error beats resolve; resolve beats timeout and terminator bytes
        if (rx_error) begin
          bad_d = 1'b1;
        end else if (rx_resolve) begin
          ok_d    = 1'b1;
          grant_d = 2'b00;
          state_d = S_Idle;
          if (own_v) begin
            load_d = 1'b1;
            data_d = own_d;
          end
        end else if (own_term || timed_out) begin
          bad_d = 1'b1;
        end else if (own_v) begin
          load_d  = 1'b1;
          data_d  = own_d;
          timer_d = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
        if (bad_d) begin
          grant_d = 2'b00;
          state_d = S_Flush;
        end
      end
      S_Flush: begin
        state_d = S_Idle;
      end
      default: begin
        state_d = S_Idle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_Idle;
      timer        <= '0;
      prefer_b     <= 1'b0;
      grant        <= 2'b00;
      rx_load      <= 1'b0;
      rx_data      <= '0;
      rx_restart   <= 1'b0;
      sentence_ok  <= 1'b0;
      sentence_bad <= 1'b0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      prefer_b     <= prefer_b_d;
      grant        <= grant_d;
      rx_load      <= load_d;
      rx_data      <= data_d;
      rx_restart   <= bad_d;
      sentence_ok  <= ok_d;
      sentence_bad <= bad_d;
    end
  end

  // counters only move on an event and stick at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ok_q  <= '0;
      bad_q <= '0;
    end else begin
      if (ok_d && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
      if (bad_d && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
    end
  end

  assign ok_count  = ok_q;
  assign bad_count = bad_q;

endmodule

// File: tb/tb_gps_feed_arbiter.sv
// tb_gps_feed_arbiter: directed and random feeds against a sentence-level
// reference model; a monitor pops expected output events from a queue.
module tb_gps_feed_arbiter;

  localparam int         TO    = 40;
  localparam logic [7:0] START = 8'h24;
  localparam logic [7:0] EOL   = 8'h0A;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0]  a_data = '0, b_data = '0;
  logic        rx_resolve = 1'b0, rx_error = 1'b0;
  logic        rx_load, rx_restart, sentence_ok, sentence_bad;
  logic [7:0]  rx_data;
  logic [1:0]  grant;
  logic [15:0] ok_count, bad_count;

  gps_feed_arbiter #(.B(8), .Timeout(TO), .Start(START), .EndOfLine(EOL)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_data(a_data),
    .b_valid(b_valid), .b_data(b_data),
    .rx_load(rx_load), .rx_data(rx_data), .rx_restart(rx_restart),
    .rx_resolve(rx_resolve), .rx_error(rx_error),
    .grant(grant), .sentence_ok(sentence_ok), .sentence_bad(sentence_bad),
    .ok_count(ok_count), .bad_count(bad_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ld;
    logic [7:0]  d;
    logic        ok;
    logic        bad;
    logic        rs;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  restart_seen = 0;

  // reference model: who owns the receiver, idle time, outcome tallies
  int          m_owner;
  bit          m_flush, m_prefer_b, m_expect_evt;
  int          m_idle;
  logic [15:0] m_okc, m_badc;
  logic [1:0]  m_grant;
  logic [7:0]  m_data;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = 0; m_flush = 0; m_prefer_b = 0; m_idle = 0;
    m_okc = '0; m_badc = '0; m_grant = 2'b00; m_data = '0;
    m_expect_evt = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit av, input logic [7:0] ad,
                            input bit bv, input logic [7:0] bd,
                            input bit res, input bit err);
    ev_t e;
    bit abort, sa, sb, win_b, ov;
    logic [7:0] od;
    e = '0;
    abort = 0;
    if (m_flush) begin
      m_flush = 0;
    end else if (m_owner == 0) begin
      sa = av && ad == START;
      sb = bv && bd == START;
      if (sa || sb) begin
        win_b = (sa && sb) ? m_prefer_b : sb;
        m_owner = win_b ? 2 : 1;
        m_prefer_b = !win_b;
        m_idle = 0;
        e.ld = 1; e.d = START;
      end
    end else begin
      ov = (m_owner == 1) ? av : bv;
      od = (m_owner == 1) ? ad : bd;
      if (err) abort = 1;
      else if (res) begin
        if (ov) begin e.ld = 1; e.d = od; end
        e.ok = 1;
        if (m_okc != 16'hFFFF) m_okc++;
        m_owner = 0;
      end
      else if (ov && (od == EOL || od == START)) abort = 1;
      else if (m_idle == TO) abort = 1;
      else if (ov) begin e.ld = 1; e.d = od; m_idle = 0; end
      else m_idle++;
    end
    if (abort) begin
      e.bad = 1; e.rs = 1;
      if (m_badc != 16'hFFFF) m_badc++;
      m_owner = 0;
      m_flush = 1;
    end
    m_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    if (e.ld) m_data = e.d;
    m_expect_evt = e.ld | e.ok | e.bad | e.rs;
    if (m_expect_evt) exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      if (rx_restart) restart_seen++;
      chk("ok_bad_exclusive", {31'd0, sentence_ok & sentence_bad}, 0);
      chk("grant", {30'd0, grant}, {30'd0, m_grant});
      chk("ok_count", {16'd0, ok_count}, {16'd0, m_okc});
      chk("bad_count", {16'd0, bad_count}, {16'd0, m_badc});
      chk("rx_data", {24'd0, rx_data}, {24'd0, m_data});
      chk("event_present",
          {31'd0, rx_load | sentence_ok | sentence_bad | rx_restart},
          {31'd0, m_expect_evt});
      if ((rx_load | sentence_ok | sentence_bad | rx_restart)
          && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ev_load", {31'd0, rx_load}, {31'd0, e.ld});
        if (e.ld) chk("ev_data", {24'd0, rx_data}, {24'd0, e.d});
        chk("ev_ok", {31'd0, sentence_ok}, {31'd0, e.ok});
        chk("ev_bad", {31'd0, sentence_bad}, {31'd0, e.bad});
        chk("ev_restart", {31'd0, rx_restart}, {31'd0, e.rs});
      end
    end
  end

  task automatic drive(input bit av, input logic [7:0] ad,
                       input bit bv, input logic [7:0] bd,
                       input bit res, input bit err);
    @(negedge clock);
    #2;
    a_valid = av; a_data = ad;
    b_valid = bv; b_data = bd;
    rx_resolve = res; rx_error = err;
    model_step(av, ad, bv, bd, res, err);
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  // owner sends so; the other channel sends sx one cycle behind
  task automatic stream(input bit own_b, input string so, input string sx,
                        input bit resolve_last);
    int n, m, tot;
    bit ov, xv, r;
    logic [7:0] od, xd;
    n = so.len();
    m = sx.len();
    tot = (n > m + 1) ? n : m + 1;
    for (int i = 0; i < tot; i++) begin
      ov = i < n;
      od = ov ? so[i] : 8'h00;
      xv = (i >= 1) && (i - 1 < m);
      xd = xv ? sx[i-1] : 8'h00;
      r  = resolve_last && (i == n - 1);
      if (own_b) drive(xv, xd, ov, od, r, 0);
      else drive(ov, od, xv, xd, r, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_valid = 0; b_valid = 0; rx_resolve = 0; rx_error = 0;
    m_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_load"}, {31'd0, rx_load}, 0);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, 0);
    chk({tag, "_rx_restart"}, {31'd0, rx_restart}, 0);
    chk({tag, "_grant"}, {30'd0, grant}, 0);
    chk({tag, "_ok"}, {31'd0, sentence_ok}, 0);
    chk({tag, "_bad"}, {31'd0, sentence_bad}, 0);
    chk({tag, "_ok_count"}, {16'd0, ok_count}, 0);
    chk({tag, "_bad_count"}, {16'd0, bad_count}, 0);
  endtask

  string s_zda = "$GPZDA,201530.00,04,07,2002,00,00*60\r\n";
  string s_gga = "$GPGGA,1,2*4F\r\n";
  string s_rmc = "$GPRMC,123519,A*6A\r\n";
  logic [7:0] alpha [8] = '{8'h24, 8'h0A, "G", "P", ",", "*", "0", "A"};

  initial begin
    int rs0;
    bit av, bv, res, err;
    m_reset();
    repeat (2) @(negedge clock);
    #1 chk_all_zero("reset");
    reset = 1'b0;

    // single sentence on A, resolved on its line feed
    stream(0, s_zda, "", 1);
    #1;
    chk("zda_ok_count", {16'd0, ok_count}, 1);
    chk("zda_grant_released", {30'd0, grant}, 0);

    // simultaneous starts alternate owners
    do_reset();
    drive(1, START, 1, START, 0, 0);
    #1 chk("rr_first", {30'd0, grant}, 2'b01);
    drive(0, 8'h00, 0, 8'h00, 1, 0);
    drive(1, START, 1, START, 0, 0);
    #1 chk("rr_second", {30'd0, grant}, 2'b10);
    drive(0, 8'h00, 0, 8'h00, 1, 0);

    // B owns while A streams a whole sentence
    stream(1, s_gga, s_rmc, 1);
    #1 chk("b_owner_ok_count", {16'd0, ok_count}, 3);

    // idle owner times out
    rs0 = restart_seen;
    drive(1, START, 0, 8'h00, 0, 0);
    idle(TO + 4);
    #1;
    chk("timeout_bad_count", {16'd0, bad_count}, 1);
    chk("timeout_restart_once", restart_seen - rs0, 1);
    drive(0, 8'h00, 1, START, 0, 0);
    #1 chk("after_timeout_lock", {30'd0, grant}, 2'b10);
    drive(0, 8'h00, 0, 8'h00, 1, 0);

    // error and resolve together, then a start inside the flush cycle
    drive(1, START, 0, 8'h00, 0, 0);
    drive(1, "G", 0, 8'h00, 1, 1);
    #1;
    chk("err_res_bad", {31'd0, sentence_bad}, 1);
    chk("err_res_no_ok", {31'd0, sentence_ok}, 0);
    chk("err_res_ok_count", {16'd0, ok_count}, 4);
    chk("err_res_bad_count", {16'd0, bad_count}, 2);
    drive(1, START, 0, 8'h00, 0, 0);
    #1 chk("flush_ignores_start", {30'd0, grant}, 2'b00);
    drive(1, START, 0, 8'h00, 0, 0);
    #1 chk("post_flush_lock", {30'd0, grant}, 2'b01);
    drive(0, 8'h00, 0, 8'h00, 1, 0);

    // random traffic with occasional long silences
    for (int i = 0; i < 3000; i++) begin
      av  = $urandom_range(0, 2) == 0;
      bv  = $urandom_range(0, 2) == 0;
      res = $urandom_range(0, 15) == 0;
      err = $urandom_range(0, 39) == 0;
      drive(av, alpha[$urandom_range(0, 7)], bv, alpha[$urandom_range(0, 7)],
            res, err);
      if (i % 500 == 499) idle(TO + 3);
    end
    drive(0, 8'h00, 0, 8'h00, 0, 1);
    idle(3);

    // saturation from a preloaded count
    force dut.ok_q = 16'hFFFE;
    #1 release dut.ok_q;
    m_okc = 16'hFFFE;
    stream(0, s_gga, "", 1);
    stream(1, s_rmc, "", 1);
    stream(0, s_zda, "", 1);
    #1 chk("ok_saturated", {16'd0, ok_count}, 16'hFFFF);

    // asynchronous reset in the middle of a sentence
    drive(1, START, 0, 8'h00, 0, 0);
    drive(1, "G", 0, 8'h00, 0, 0);
    drive(1, "P", 0, 8'h00, 0, 0);
    #3 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    do_reset();
    stream(0, "GPZ,1*00", "", 0);
    drive(1, START, 0, 8'h00, 0, 0);
    #1 chk("fresh_lock", {30'd0, grant}, 2'b01);
    stream(0, "GPZDA*00\r\n", "", 1);
    #1 chk("fresh_ok_count", {16'd0, ok_count}, 1);

    idle(3);
    @(negedge clock);
    #1 chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_feed_arbiter.md
GPS_FEED_ARBITER -- requirements
Module: gps_feed_arbiter

Interface
REQ-001 Parameter: B, 8, bits per byte.
REQ-002 Parameter: Timeout, 100000, idle-cycle limit inside a locked sentence (1 ms at 100 MHz).
REQ-003 Parameter: Start, "$", sentence start byte.
REQ-004 Parameter: EndOfLine, 8'h0A, line terminator byte.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 Port: clock  in  1  system clock, 100 MHz / 10 ns.
REQ-007 Port: reset  in  1  asynchronous, active-high reset.
REQ-008 Port: a_valid  in  1  one-cycle strobe, byte on channel A; no backpressure.
REQ-009 Port: a_data  in  B  channel A byte.
REQ-010 Port: b_valid  in  1  one-cycle strobe, byte on channel B; no backpressure.
REQ-011 Port: b_data  in  B  channel B byte.
REQ-012 Port: rx_load  out  1  byte strobe to the shared GPS receiver.
REQ-013 Port: rx_data  out  B  byte to the shared GPS receiver.
REQ-014 Port: rx_restart  out  1  one-cycle pulse that returns the receiver to prefix search.
REQ-015 Port: rx_resolve  in  1  receiver finished a sentence.
REQ-016 Port: rx_error  in  1  receiver flags malformed data.
REQ-017 Port: grant  out  2  one-hot owner, bit0 = A, bit1 = B; 2'b00 = none.
REQ-018 Port: sentence_ok  out  1  one-cycle pulse, sentence accepted.
REQ-019 Port: sentence_bad  out  1  one-cycle pulse, sentence aborted.
REQ-020 Port: ok_count  out  16  accepted sentences, saturating.
REQ-021 Port: bad_count  out  16  aborted sentences, saturating.

Function
REQ-022 FSM states: S_Idle (no owner), S_Lock (owner forwarding), S_Flush (abort cleanup).
REQ-023 S_Idle: a valid byte equal to Start on A or B shall take ownership; state goes to S_Lock next cycle; grant is set next cycle.
REQ-024 S_Idle, Start on A and B in the same cycle: the channel not granted last time wins (round-robin); after reset, A wins.
REQ-025 S_Idle: non-Start bytes on either channel shall be dropped; no rx_load.
REQ-026 Forwarding: the owner byte (including the Start that caused the lock) at cycle t shall appear as rx_load=1 and rx_data=byte at cycle t+1.
REQ-027 Forwarding: rx_load shall be 0 in every other cycle; rx_data shall hold its last value.
REQ-028 Non-owner bytes: dropped in S_Lock and S_Flush.
REQ-029 S_Lock: an idle timer shall clear on each owner byte and otherwise increment.
REQ-030 S_Lock: when the timer reaches Timeout -> abort.
REQ-031 S_Lock abort triggers: rx_error=1; owner byte equal to EndOfLine before rx_resolve; owner byte equal to Start (new sentence) before rx_resolve. The aborting byte shall not be forwarded.
REQ-032 S_Lock, rx_resolve=1 with rx_error=0: sentence_ok pulses next cycle; ok_count +1; grant clears; state goes to S_Idle.
REQ-033 After release, the owner's remaining bytes shall be dropped until a new Start.
REQ-034 Abort: sentence_bad pulses next cycle; bad_count +1; grant clears; state goes to S_Flush.
REQ-035 S_Flush: rx_restart=1 for exactly one cycle, then state goes to S_Idle; a Start during S_Flush shall be ignored.
REQ-036 Priority in the same cycle: rx_error over rx_resolve; rx_resolve over timeout; rx_resolve over an EndOfLine/Start abort byte.
REQ-037 Counters: saturate at 16'hFFFF and never wrap.
REQ-038 sentence_ok and sentence_bad shall never be high in the same cycle.

Reset
REQ-039 Reset (async, any state) shall force S_Idle and clear the timer, the round-robin pointer (A preferred), grant, rx_load, rx_data, rx_restart, sentence_ok, sentence_bad, ok_count and bad_count to 0.
REQ-040 Reset mid-sentence shall forward no further bytes; the first Start after reset deasserts starts a fresh lock.

Verification
REQ-041 A sends "$GPZDA,..." and the receiver model asserts rx_resolve -> grant=01 from the cycle after '$'; every A byte mirrored on rx_data one cycle later; sentence_ok pulse; ok_count=1; grant=00.
REQ-042 '$' on A and B in the same cycle, twice in a row (each completed) -> first grant=01, second grant=10.
REQ-043 B locked and A streams a full sentence meanwhile -> no A byte appears on rx_load.
REQ-044 A locked, then silent for Timeout cycles -> sentence_bad; bad_count=1; rx_restart pulses once; then S_Idle.
REQ-045 rx_resolve and rx_error both high in one cycle -> sentence_bad only; ok_count unchanged.
REQ-046 Preload ok_count=16'hFFFE, then send 3 good sentences -> ok_count=16'hFFFF; async reset asserted mid-sentence -> all outputs 0 immediately.
